// File: rtl/echo_timer_pkg.sv
// -----------------------------------------------------------------------------
// echo_timer_pkg
// Shared definitions for the ultrasonic echo timer:
//   - counter width and default timing constants at 50 MHz
//   - FSM state encoding (3-bit)
//   - saturating increment helper used by the period counter
// -----------------------------------------------------------------------------
package echo_timer_pkg;

  localparam int unsigned CNT_W             = 24;
  localparam int unsigned TRIG_CYCLES_DEF   = 500;         // 10 us trigger pulse
  localparam int unsigned MAX_COUNT_DEF     = 12_500_000;  // echo timeout / saturation
  localparam int unsigned PERIOD_CYCLES_DEF = 3_000_000;   // 60 ms trigger-to-trigger

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_MEASURE = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic count_t sat_inc(input count_t v, input count_t lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/echo_timer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous inputs. Output lags the input
// by two clock cycles; both stages reset to 0.
// Ports:
//   clk  in          system clock
//   rst  in          synchronous, active-high reset
//   d_i  in  [W-1:0] asynchronous input
//   q_o  out [W-1:0] synchronised output
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: flops use non-blocking assignments so both stages sample the
  // pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/echo_timer.sv
// -----------------------------------------------------------------------------
// echo_timer
// Drives an ultrasonic ranger: emits a trigger pulse, then measures the echo
// high-time in clock cycles and reports it with a one-cycle valid strobe.
// Ports:
//   clk      in        system clock
//   rst      in        synchronous, active-high reset
//   enable   in        1 = measure continuously, 0 = stop after current cycle
//   echo     in        asynchronous sensor echo pin
//   trig     out       sensor trigger pin
//   value    out [23:0] last echo width in cycles, held until next valid
//   valid    out       one-cycle strobe, value updated in the same cycle
//   timeout  out       qualifies valid: no echo / echo too long
//   busy     out       1 in every state except IDLE
// -----------------------------------------------------------------------------
module echo_timer
  import echo_timer_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int unsigned MAX_COUNT     = MAX_COUNT_DEF,
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic [CNT_W-1:0] value,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam count_t TRIG_LAST = count_t'(TRIG_CYCLES - 1);
  localparam count_t MAX_LAST  = count_t'(MAX_COUNT - 1);
  localparam count_t MAX_VAL   = count_t'(MAX_COUNT);
  localparam count_t PERIOD    = count_t'(PERIOD_CYCLES);

  logic   echo_s;
  state_e state_q, state_d;
  count_t cnt_q, cnt_d;       // phase counter: trigger, wait, width
  count_t per_q, per_d;       // cycles since trigger rise, 1 in first TRIG cycle
  logic   armed_q, armed_d;   // echo_s seen low in WAIT_HI, so a 1 is a real edge
  count_t value_q, value_d;
  logic   valid_q, valid_d;
  logic   timeout_q, timeout_d;
  logic   trig_q, busy_q;
  logic   hit_max;

  sync_2ff #(.WIDTH(1)) u_echo_sync (
    .clk (clk),
    .rst (rst),
    .d_i (echo),
    .q_o (echo_s)
  );

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = sat_inc(per_q, PERIOD);
    armed_d   = armed_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    hit_max   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        per_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = ST_TRIG;
          per_d   = count_t'(1);
        end
      end
      ST_TRIG: begin
        armed_d = 1'b0;
        if (cnt_q >= TRIG_LAST) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HI: begin
        // This cycle is the first high cycle of the pulse, hence width 1.
        if (echo_s && armed_q) begin
          state_d = ST_MEASURE;
          cnt_d   = count_t'(1);
        end else if (cnt_q >= MAX_LAST) begin
          hit_max = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!echo_s) armed_d = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_s) begin
          value_d = cnt_q;
          valid_d = 1'b1;
          state_d = ST_HOLDOFF;
        end else if (cnt_q >= MAX_LAST) begin
          hit_max = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (per_q >= PERIOD) begin
          if (enable) begin
            state_d = ST_TRIG;
            per_d   = count_t'(1);
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hit_max) begin
      value_d   = MAX_VAL;
      valid_d   = 1'b1;
      timeout_d = 1'b1;
      state_d   = ST_HOLDOFF;
    end
  end

  // trig and busy are registered from the next state so they line up with
  // state_q without a decode glitch on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      armed_q   <= 1'b0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      armed_q   <= armed_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      trig_q    <= (state_d == ST_TRIG);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign trig    = trig_q;
  assign value   = value_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_echo_timer.sv
// -----------------------------------------------------------------------------
// tb_echo_timer
// Directed bench for echo_timer with TRIG=10, MAX=1000, PERIOD=2000.
// Stimulus pushes the expected (value, timeout) of each measurement into a
// queue; a monitor pops and compares on every valid strobe.
// -----------------------------------------------------------------------------
module tb_echo_timer;

  localparam int TRIG   = 10;
  localparam int MAXC   = 1000;
  localparam int PERIOD = 2000;

  typedef struct {
    logic [23:0] value;
    logic        timeout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [23:0] value;
  logic        valid;
  logic        timeout;
  logic        busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   vcount   = 0;
  int   last_valid_cyc = -1;
  logic valid_prev = 1'b0;
  exp_t sb_q[$];

  echo_timer #(
    .TRIG_CYCLES   (TRIG),
    .MAX_COUNT     (MAXC),
    .PERIOD_CYCLES (PERIOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .echo    (echo),
    .trig    (trig),
    .value   (value),
    .valid   (valid),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_meas(input int v, input logic to);
    exp_t e;
    e.value   = 24'(v);
    e.timeout = to;
    sb_q.push_back(e);
  endtask

  // which: 0 = trig, 1 = busy. Returns cycle of first negedge at level lvl.
  task automatic wait_sig(input string name, input int which, input logic lvl,
                          input int limit, output int at);
    logic s;
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      s = (which == 0) ? trig : busy;
      if (s == lvl) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: signal never reached %0b within %0d cycles", name, lvl, limit);
    end
  endtask

  task automatic wait_valid(input string name, input int target, input int limit);
    int n = 0;
    while (vcount < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, vcount, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"},    trig,    0);
    check({tag, "_value"},   value,   0);
    check({tag, "_valid"},   valid,   0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_busy"},    busy,    0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      vcount++;
      last_valid_cyc = cyc;
      check("valid_one_cycle", valid_prev, 0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: value=%0d timeout=%0b, none expected (cycle %0d)",
                 value, timeout, cyc);
      end else begin
        e = sb_q.pop_front();
        check("meas_value",   value,   e.value);
        check("meas_timeout", timeout, e.timeout);
      end
    end else if (timeout) begin
      check("timeout_without_valid", timeout, 0);
    end
    valid_prev = valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r1, r2, r3, r4, r5, r6, r7, f1, f2, f3, f4, f5, f7, b5;
    logic seen;

    rst = 1'b1; enable = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: trigger pulse width and busy
    enable = 1'b1;
    wait_sig("trig_rise_1", 0, 1'b1, 10, r1);
    check("busy_in_trig", busy, 1);
    wait_sig("trig_fall_1", 0, 1'b0, 50, f1);
    check("trig_width", f1 - r1, TRIG);

    // 2: normal 237-cycle echo
    repeat (5) @(negedge clk);
    expect_meas(237, 1'b0);
    echo = 1'b1;
    repeat (237) @(negedge clk);
    echo = 1'b0;
    wait_valid("meas_a_seen", 1, 20);

    // 5 (part): continuous enable gives 2000-cycle spacing
    wait_sig("trig_rise_2", 0, 1'b1, 3000, r2);
    check("period_1", r2 - r1, PERIOD);

    // 3: no echo -> timeout 1000 cycles after WAIT_HI entry
    wait_sig("trig_fall_2", 0, 1'b0, 50, f2);
    expect_meas(MAXC, 1'b1);
    wait_valid("meas_b_seen", 2, 1100);
    check("wait_hi_timeout_latency", last_valid_cyc - f2, MAXC);

    // 4a: echo stuck high from before the trigger
    echo = 1'b1;
    wait_sig("trig_rise_3", 0, 1'b1, 3000, r3);
    check("period_2", r3 - r2, PERIOD);
    wait_sig("trig_fall_3", 0, 1'b0, 50, f3);
    repeat (300) @(negedge clk);
    check("stale_echo_ignored", vcount, 2);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    expect_meas(50, 1'b0);
    echo = 1'b1;
    repeat (50) @(negedge clk);
    echo = 1'b0;
    wait_valid("meas_c_seen", 3, 20);

    // 4b: echo high longer than MAX_COUNT -> timeout
    wait_sig("trig_rise_4", 0, 1'b1, 3000, r4);
    check("period_3", r4 - r3, PERIOD);
    wait_sig("trig_fall_4", 0, 1'b0, 50, f4);
    repeat (5) @(negedge clk);
    expect_meas(MAXC, 1'b1);
    echo = 1'b1;
    repeat (1200) @(negedge clk);
    echo = 1'b0;
    check("meas_d_seen", vcount, 4);

    // 5: enable dropped mid-measurement; result still reported, then IDLE
    wait_sig("trig_rise_5", 0, 1'b1, 3000, r5);
    check("period_4", r5 - r4, PERIOD);
    wait_sig("trig_fall_5", 0, 1'b0, 50, f5);
    repeat (5) @(negedge clk);
    expect_meas(100, 1'b0);
    echo = 1'b1;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (70) @(negedge clk);
    echo = 1'b0;
    wait_sig("busy_fall_5", 1, 1'b0, 3000, b5);
    check("idle_at_period_end", b5 - r5, PERIOD);
    check("meas_e_seen", vcount, 5);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (trig || busy) seen = 1'b1;
    end
    check("no_retrigger_when_disabled", seen, 0);

    // 6a: reset in the middle of TRIG
    enable = 1'b1;
    wait_sig("trig_rise_6", 0, 1'b1, 5, r6);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid_trig");
    rst = 1'b0;

    // 6b: reset in the middle of MEASURE
    wait_sig("trig_rise_7", 0, 1'b1, 5, r7);
    wait_sig("trig_fall_7", 0, 1'b0, 50, f7);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid_measure");
    enable = 1'b0;
    rst    = 1'b0;
    echo   = 1'b0;
    repeat (50) @(negedge clk);
    check("no_valid_after_abort", vcount, 5);
    check("scoreboard_drained", sb_q.size(), 0);
    check("idle_after_abort", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
